brush_mapper: RTL and testbench
===============================

BRUSH_MAPPER -- requirements
Module: brush_mapper

Interface
REQ-001 SHALL have parameter COORD_W, 10, pixel/brush coordinate width.
REQ-002 SHALL have parameter COLOR_W, 8, per-channel colour width.
REQ-003 SHALL have parameter NUM_COLORS, 4, usable palette entries (2..8).
REQ-004 SHALL have parameters CANVAS_X0/X1/Y0/Y1, 100/540/100/380, inclusive canvas bounds.
REQ-005 SHALL have port Clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port frame_start  in  1  one-cycle pulse at start of each frame.
REQ-008 SHALL have port pix_valid_in  in  1  DrawX/DrawY/Prev colours valid this cycle.
REQ-009 SHALL have ports DrawX, DrawY  in  COORD_W  current pixel.
REQ-010 SHALL have ports BrushX, BrushY, Brush_size  in  COORD_W  brush centre and radius.
REQ-011 SHALL have ports left_btn, right_btn  in  1  paint / erase request.
REQ-012 SHALL have port color_sel  in  3  palette index request.
REQ-013 SHALL have ports RedPrev, GreenPrev, BluePrev  in  COLOR_W  stored canvas pixel.
REQ-014 SHALL have ports Red, Green, Blue  out  COLOR_W  registered pixel colour.
REQ-015 SHALL have port pix_valid_out  out  1  Red/Green/Blue valid.
REQ-016 SHALL have port stroke_state  out  2  current FSM state encoding.

Function
REQ-017 SHALL implement FSM IDLE(00), PAINT(01), ERASE(10), evaluated only on cycles with frame_start=1.
REQ-018 At frame_start: left_btn=1 -> PAINT; else right_btn=1 -> ERASE; else IDLE; left wins when both high.
REQ-019 SHALL latch Brush_size, BrushX, BrushY and color_sel on frame_start; values stay constant for the whole frame.
REQ-020 color_sel >= NUM_COLORS SHALL latch index 0.
REQ-021 SHALL be a 2-stage pipeline: stage 1 registers signed dx=DrawX-BrushX, dy=DrawY-BrushY (COORD_W+1 bits) and canvas flag; stage 2 registers colour; latency exactly 2 cycles, pix_valid_out = pix_valid_in delayed 2.
REQ-022 Distance test SHALL be dx*dx+dy*dy <= size*size, computed at 2*COORD_W+3 bits with no overflow or truncation.
REQ-023 Pixel outside canvas bounds (inclusive) SHALL output 0x88 on all channels, regardless of state.
REQ-024 Inside canvas and inside brush: PAINT -> palette[index]; ERASE -> 0x00 all channels; IDLE -> 0xFF all channels (preview).
REQ-025 Inside canvas, outside brush SHALL output Prev colours delayed through the pipeline unchanged.
REQ-026 Brush_size=0 SHALL mark only the pixel at the centre as inside the brush.
REQ-027 frame_start coinciding with pix_valid_in SHALL apply the new latched values starting with that same pixel.
REQ-028 Pipeline SHALL process every cycle without stalls; gaps in pix_valid_in SHALL propagate as gaps.

Reset
REQ-029 Reset SHALL clear FSM to IDLE, latched size/position/index to 0, pipeline valids to 0, Red/Green/Blue to 0.
REQ-030 Reset asserted mid-frame SHALL discard in-flight pixels; pix_valid_out is 0 in the cycle after Reset is sampled and remains 0 until new valid input has passed both stages.

Configuration
REQ-031 With BRUSH_RING_EN defined, pixels inside the canvas with (size-1)^2 < dist2 <= size^2 SHALL output 0xFF,0xFF,0x00 in every state, overriding REQ-024 (size=0 gives no ring).
REQ-032 Without BRUSH_RING_EN, no ring comparator SHALL exist and REQ-024 applies unchanged.

Structure
REQ-033 Package brush_pkg SHALL hold the state enum, the 8-entry palette constant (magenta, red, green, blue, cyan, yellow, white, orange) and the 0x88 border constant.
REQ-034 Distance-squared computation SHALL be a sub-module brush_dist2, instantiated once (twice for the ring's inner radius is not allowed; reuse dx/dy).

Verification
REQ-035 Reset, then frame_start with left_btn=1, color_sel=1, brush (320,240) r=10; pixel (325,245) -> after 2 cycles 0xFF,0x00,0x00, pix_valid_out=1.
REQ-036 Pixel (50,50) in any state -> 0x88,0x88,0x88.
REQ-037 Both buttons high at frame_start -> stroke_state=01; only right_btn -> 10 and brush pixel 0x00.
REQ-038 Change Brush_size mid-frame 10->20; pixel at distance 15 stays pass-through until next frame_start.
REQ-039 color_sel=6 with NUM_COLORS=4 -> painted pixel magenta (index 0).
REQ-040 Reset asserted with valid pixels in flight -> pix_valid_out=0 next cycle, outputs 0, stroke_state=00.

Source files
------------

// File: rtl/brush_pkg.sv
// rtl/brush_pkg.sv - stroke state type, palette and border constants for brush_mapper
package brush_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PAINT = 2'b01,
    ST_ERASE = 2'b10
  } stroke_t;

  // Level driven on every channel for pixels outside the canvas
  localparam logic [7:0] BORDER_LVL = 8'h88;

  // Packed {R,G,B}: magenta, red, green, blue, cyan, yellow, white, orange
  localparam logic [23:0] PALETTE [8] = '{
    24'hFF00FF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
    24'h00FFFF, 24'hFFFF00, 24'hFFFFFF, 24'hFFA500
  };

  // Left button has priority over right when both are held
  function automatic stroke_t next_stroke(input logic left_btn, input logic right_btn);
    if (left_btn)       return ST_PAINT;
    else if (right_btn) return ST_ERASE;
    else                return ST_IDLE;
  endfunction

endpackage

// File: rtl/brush_dist2.sv
// rtl/brush_dist2.sv - squared Euclidean distance from signed dx/dy
module brush_dist2 #(
  parameter int COORD_W = 10
) (
  input  logic signed [COORD_W:0]     dx,
  input  logic signed [COORD_W:0]     dy,
  output logic        [2*COORD_W+2:0] dist2
);

  localparam int DW = 2*COORD_W + 3;

  logic signed [DW-1:0] dx_ext, dy_ext, dx_sq, dy_sq;

  // Sign-extend to full result width first so neither square nor sum can overflow
  always_comb begin
    dx_ext = {{(DW-COORD_W-1){dx[COORD_W]}}, dx};
    dy_ext = {{(DW-COORD_W-1){dy[COORD_W]}}, dy};
    dx_sq  = dx_ext * dx_ext;
    dy_sq  = dy_ext * dy_ext;
    dist2  = dx_sq + dy_sq;
  end

endmodule

// File: rtl/brush_mapper.sv
// rtl/brush_mapper.sv - 2-stage brush/canvas pixel colour mapper; optional outline ring via BRUSH_RING_EN
module brush_mapper
  import brush_pkg::*;
#(
  parameter int COORD_W    = 10,
  parameter int COLOR_W    = 8,
  parameter int NUM_COLORS = 4,
  parameter int CANVAS_X0  = 100,
  parameter int CANVAS_X1  = 540,
  parameter int CANVAS_Y0  = 100,
  parameter int CANVAS_Y1  = 380
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic               pix_valid_in,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic [COORD_W-1:0] BrushX,
  input  logic [COORD_W-1:0] BrushY,
  input  logic [COORD_W-1:0] Brush_size,
  input  logic               left_btn,
  input  logic               right_btn,
  input  logic [2:0]         color_sel,
  input  logic [COLOR_W-1:0] RedPrev,
  input  logic [COLOR_W-1:0] GreenPrev,
  input  logic [COLOR_W-1:0] BluePrev,
  output logic [COLOR_W-1:0] Red,
  output logic [COLOR_W-1:0] Green,
  output logic [COLOR_W-1:0] Blue,
  output logic               pix_valid_out,
  output logic [1:0]         stroke_state
);

  localparam int DW = 2*COORD_W + 3;
  localparam logic [COORD_W-1:0] CX0 = COORD_W'(CANVAS_X0);
  localparam logic [COORD_W-1:0] CX1 = COORD_W'(CANVAS_X1);
  localparam logic [COORD_W-1:0] CY0 = COORD_W'(CANVAS_Y0);
  localparam logic [COORD_W-1:0] CY1 = COORD_W'(CANVAS_Y1);
  localparam logic [3:0]         NUM_C = 4'(NUM_COLORS);
  localparam logic [COLOR_W-1:0] ALL_ONES = {COLOR_W{1'b1}};

  stroke_t              state_q, state_d;
  logic [COORD_W-1:0]   size_q, bx_q, by_q;
  logic [2:0]           idx_q;

  logic [COORD_W-1:0]   eff_bx, eff_by, eff_size;
  logic [2:0]           sel_idx, eff_idx;

  logic                 s1_valid, s1_canvas;
  logic signed [COORD_W:0] s1_dx, s1_dy;
  stroke_t              s1_state;
  logic [2:0]           s1_idx;
  logic [COORD_W-1:0]   s1_size;
  logic [COLOR_W-1:0]   s1_r, s1_g, s1_b;

  logic [DW-1:0]        dist2, size_ext, size_sq;
  logic                 in_brush, in_ring;
  logic [23:0]          pal;
  logic [COLOR_W-1:0]   nxt_r, nxt_g, nxt_b;

  // Stroke state register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Stroke state only moves on frame boundaries
  always_comb begin
    state_d = state_q;
    if (frame_start) state_d = next_stroke(left_btn, right_btn);
  end

  // Expose current stroke state
  always_comb begin
    stroke_state = state_q;
  end

  // Hold brush geometry and palette index for the whole frame
  always_ff @(posedge Clk) begin
    if (Reset) begin
      size_q <= '0;
      bx_q   <= '0;
      by_q   <= '0;
      idx_q  <= '0;
    end else if (frame_start) begin
      size_q <= Brush_size;
      bx_q   <= BrushX;
      by_q   <= BrushY;
      idx_q  <= sel_idx;
    end
  end

  // A pixel arriving with frame_start already uses the new frame's values
  always_comb begin
    sel_idx  = ({1'b0, color_sel} >= NUM_C) ? 3'd0 : color_sel;
    eff_bx   = frame_start ? BrushX     : bx_q;
    eff_by   = frame_start ? BrushY     : by_q;
    eff_size = frame_start ? Brush_size : size_q;
    eff_idx  = frame_start ? sel_idx    : idx_q;
  end

  // Stage 1: offsets from brush centre, canvas test, and per-pixel context
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid  <= 1'b0;
      s1_canvas <= 1'b0;
      s1_dx     <= '0;
      s1_dy     <= '0;
      s1_state  <= ST_IDLE;
      s1_idx    <= '0;
      s1_size   <= '0;
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
    end else begin
      s1_valid  <= pix_valid_in;
      s1_canvas <= (DrawX >= CX0) && (DrawX <= CX1) && (DrawY >= CY0) && (DrawY <= CY1);
      s1_dx     <= {1'b0, DrawX} - {1'b0, eff_bx};
      s1_dy     <= {1'b0, DrawY} - {1'b0, eff_by};
      s1_state  <= state_d;
      s1_idx    <= eff_idx;
      s1_size   <= eff_size;
      s1_r      <= RedPrev;
      s1_g      <= GreenPrev;
      s1_b      <= BluePrev;
    end
  end

  brush_dist2 #(.COORD_W(COORD_W)) u_dist2 (
    .dx    (s1_dx),
    .dy    (s1_dy),
    .dist2 (dist2)
  );

`ifdef BRUSH_RING_EN
  logic [DW-1:0] size_m1, inner_sq;

  // Outline ring: the outermost radius step of the brush disc
  always_comb begin
    size_m1  = DW'(s1_size) - DW'(1);
    inner_sq = size_m1 * size_m1;
    in_ring  = (s1_size != '0) && in_brush && (dist2 > inner_sq);
  end
`else
  // No ring in this build
  always_comb begin
    in_ring = 1'b0;
  end
`endif

  // Stage 2 colour select: border, ring, brush action, else pass-through
  always_comb begin
    size_ext = DW'(s1_size);
    size_sq  = size_ext * size_ext;
    in_brush = (dist2 <= size_sq);
    pal      = PALETTE[s1_idx];
    nxt_r    = s1_r;
    nxt_g    = s1_g;
    nxt_b    = s1_b;
    if (!s1_canvas) begin
      nxt_r = COLOR_W'(BORDER_LVL);
      nxt_g = COLOR_W'(BORDER_LVL);
      nxt_b = COLOR_W'(BORDER_LVL);
    end else if (in_ring) begin
      nxt_r = ALL_ONES;
      nxt_g = ALL_ONES;
      nxt_b = '0;
    end else if (in_brush) begin
      unique case (s1_state)
        ST_PAINT: begin
          nxt_r = COLOR_W'(pal[23:16]);
          nxt_g = COLOR_W'(pal[15:8]);
          nxt_b = COLOR_W'(pal[7:0]);
        end
        ST_ERASE: begin
          nxt_r = '0;
          nxt_g = '0;
          nxt_b = '0;
        end
        default: begin
          nxt_r = ALL_ONES;
          nxt_g = ALL_ONES;
          nxt_b = ALL_ONES;
        end
      endcase
    end
  end

  // Stage 2 output register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_valid_out <= 1'b0;
      Red           <= '0;
      Green         <= '0;
      Blue          <= '0;
    end else begin
      pix_valid_out <= s1_valid;
      Red           <= nxt_r;
      Green         <= nxt_g;
      Blue          <= nxt_b;
    end
  end

endmodule

// File: tb/tb_brush_mapper.sv
// tb/tb_brush_mapper.sv - directed and random checks of brush_mapper against a behavioural model
module tb_brush_mapper;

  logic       Clk;
  logic       Reset, frame_start, pix_valid_in;
  logic [9:0] DrawX, DrawY, BrushX, BrushY, Brush_size;
  logic       left_btn, right_btn;
  logic [2:0] color_sel;
  logic [7:0] RedPrev, GreenPrev, BluePrev;
  logic [7:0] Red, Green, Blue;
  logic       pix_valid_out;
  logic [1:0] stroke_state;

  brush_mapper dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid_in(pix_valid_in),
    .DrawX(DrawX), .DrawY(DrawY), .BrushX(BrushX), .BrushY(BrushY), .Brush_size(Brush_size),
    .left_btn(left_btn), .right_btn(right_btn), .color_sel(color_sel),
    .RedPrev(RedPrev), .GreenPrev(GreenPrev), .BluePrev(BluePrev),
    .Red(Red), .Green(Green), .Blue(Blue), .pix_valid_out(pix_valid_out),
    .stroke_state(stroke_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit          v;
    logic [23:0] rgb;
  } exp_t;

  exp_t        exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          m_state, m_bx, m_by, m_size, m_idx;
  logic [23:0] pal_ref [8];
  logic [23:0] last_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] model_pix(input int x, input int y, input logic [23:0] prev);
    int d2, s2;
    if (x < 100 || x > 540 || y < 100 || y > 380) return 24'h888888;
    d2 = (x - m_bx) * (x - m_bx) + (y - m_by) * (y - m_by);
    s2 = m_size * m_size;
`ifdef BRUSH_RING_EN
    if (m_size > 0 && d2 <= s2 && d2 > (m_size - 1) * (m_size - 1)) return 24'hFFFF00;
`endif
    if (d2 > s2) return prev;
    case (m_state)
      1:       return pal_ref[m_idx];
      2:       return 24'h000000;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  task automatic cycle();
    exp_t e;
    if (frame_start) begin
      m_state = left_btn ? 1 : (right_btn ? 2 : 0);
      m_bx    = int'(BrushX);
      m_by    = int'(BrushY);
      m_size  = int'(Brush_size);
      m_idx   = (color_sel < 3'd4) ? int'(color_sel) : 0;
    end
    e.v   = pix_valid_in;
    e.rgb = model_pix(int'(DrawX), int'(DrawY), {RedPrev, GreenPrev, BluePrev});
    exp_q.push_back(e);
    @(posedge Clk); #1;
    frame_start = 1'b0;
    check("stroke_state", 32'(stroke_state), 32'(m_state));
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check("pix_valid_out", 32'(pix_valid_out), 32'(e.v));
      if (e.v) check("rgb", 32'({Red, Green, Blue}), 32'(e.rgb));
    end
  endtask

  task automatic pix(input int x, input int y);
    pix_valid_in = 1'b1;
    DrawX = 10'(x);
    DrawY = 10'(y);
    {RedPrev, GreenPrev, BluePrev} = 24'($urandom);
    last_prev = {RedPrev, GreenPrev, BluePrev};
    cycle();
    pix_valid_in = 1'b0;
  endtask

  task automatic idle();
    pix_valid_in = 1'b0;
    cycle();
  endtask

  task automatic set_frame(input bit l, input bit r, input int sel, input int bx, input int by, input int sz);
    frame_start = 1'b1;
    left_btn    = l;
    right_btn   = r;
    color_sel   = 3'(sel);
    BrushX      = 10'(bx);
    BrushY      = 10'(by);
    Brush_size  = 10'(sz);
  endtask

  task automatic do_reset();
    exp_t e;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("rst_valid", 32'(pix_valid_out), 32'd0);
    check("rst_rgb", 32'({Red, Green, Blue}), 32'd0);
    check("rst_state", 32'(stroke_state), 32'd0);
    Reset   = 1'b0;
    m_state = 0; m_bx = 0; m_by = 0; m_size = 0; m_idx = 0;
    exp_q.delete();
    e.v = 1'b0; e.rgb = '0;
    exp_q.push_back(e);
  endtask

  initial begin
    pal_ref = '{24'hFF00FF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
                24'h00FFFF, 24'hFFFF00, 24'hFFFFFF, 24'hFFA500};
    Reset = 1'b1; frame_start = 1'b0; pix_valid_in = 1'b0;
    DrawX = '0; DrawY = '0; BrushX = '0; BrushY = '0; Brush_size = '0;
    left_btn = 1'b0; right_btn = 1'b0; color_sel = '0;
    RedPrev = '0; GreenPrev = '0; BluePrev = '0;
    last_prev = '0;
    do_reset();
    do_reset();

    // Paint red, new frame values apply to the coincident pixel
    set_frame(1, 0, 1, 320, 240, 10);
    pix(325, 245);
    idle();
    check("paint_red", 32'({Red, Green, Blue}), 32'h00FF0000);
    check("paint_valid", 32'(pix_valid_out), 32'd1);

    // Off-canvas border, on-canvas outside brush, canvas edges
    pix(50, 50);
    idle();
    check("border", 32'({Red, Green, Blue}), 32'h00888888);
    pix(400, 300);
    idle();
    check("pass_thru", 32'({Red, Green, Blue}), 32'(last_prev));
    pix(100, 100); pix(540, 380); pix(99, 200); pix(541, 200); pix(200, 381);
    idle(); idle();

    // Both buttons -> paint; right only -> erase
    set_frame(1, 1, 2, 320, 240, 10);
    idle();
    check("both_btn", 32'(stroke_state), 32'd1);
    set_frame(0, 1, 2, 320, 240, 10);
    pix(320, 240);
    idle();
    check("erase_state", 32'(stroke_state), 32'd2);
    check("erase_rgb", 32'({Red, Green, Blue}), 32'd0);
    pix(50, 50);
    idle();
    check("border_erase", 32'({Red, Green, Blue}), 32'h00888888);

    // Mid-frame size change is ignored until next frame_start
    set_frame(1, 0, 3, 320, 240, 10);
    idle();
    Brush_size = 10'd20;
    pix(335, 240);
    idle();
    check("midframe_size", 32'({Red, Green, Blue}), 32'(last_prev));
    set_frame(1, 0, 3, 320, 240, 20);
    pix(335, 240);
    idle();
    check("newframe_size", 32'({Red, Green, Blue}), 32'h000000FF);

    // Out-of-range palette index falls back to magenta
    set_frame(1, 0, 6, 320, 240, 10);
    pix(320, 245);
    idle();
    check("sel_clamp", 32'({Red, Green, Blue}), 32'h00FF00FF);

    // Zero radius: only the centre pixel; idle preview is white
    set_frame(0, 0, 0, 200, 200, 0);
    pix(200, 200);
    idle();
    check("size0_centre", 32'({Red, Green, Blue}), 32'h00FFFFFF);
    pix(201, 200);
    idle();
    check("size0_nbr", 32'({Red, Green, Blue}), 32'(last_prev));

    // Random traffic with gaps, frame changes and mid-frame brush wobble
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0)
        set_frame(1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
                  int'($urandom_range(80, 560)), int'($urandom_range(80, 400)),
                  int'($urandom_range(0, 40)));
      else begin
        BrushX     = 10'($urandom);
        Brush_size = 10'($urandom_range(0, 60));
      end
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 3) == 0) pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        else pix(m_bx + int'($urandom_range(0, 90)) - 45, m_by + int'($urandom_range(0, 90)) - 45);
      end else idle();
    end

    // Reset with pixels in flight
    set_frame(1, 0, 1, 320, 240, 10);
    pix(320, 240);
    pix_valid_in = 1'b1;
    do_reset();
    pix_valid_in = 1'b0;
    idle();
    idle();
    set_frame(0, 1, 0, 300, 300, 5);
    pix(300, 302);
    idle();
    check("post_reset", 32'({Red, Green, Blue}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
